// File: rtl/pattern_dump_tx.sv
// pattern_dump_tx: snapshots the 8-step drum pattern on a start request and
// streams it to the UART TX byte port as an 11-byte frame:
// header, 8 ASCII-hex step codes (step 0 first), 8-bit checksum, terminator.
module pattern_dump_tx #(
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter logic [7:0] TERM         = 8'h0A,
    parameter int         BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pattern,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_BUSY,
        WAIT_READY,
        DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic [3:0] IDX_CSUM = 4'd9;
    localparam logic [3:0] IDX_LAST = 4'd10;

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [31:0] snap, snap_nx;
    logic [7:0]  csum, csum_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [7:0]  txdata_nx;
    logic        txclk_nx, busy_nx, done_nx;
    logic [3:0]  step;
    logic [3:0]  nib;
    logic [7:0]  cur_byte;

    // Map a 4-bit step code onto its upper-case ASCII hex character.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Select the frame byte for the current index from the snapshot.
    always_comb begin
        step     = idx - 4'd1;
        nib      = snap[{step[2:0], 2'b00} +: 4];
        cur_byte = hex_ascii(nib);
        if (idx == 4'd0)
            cur_byte = HEADER;
        else if (idx == IDX_CSUM)
            cur_byte = csum;
        else if (idx == IDX_LAST)
            cur_byte = TERM;
    end

    // Next-state logic; outputs follow the present state one cycle later so
    // every port comes straight from a flop.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        snap_nx   = snap;
        csum_nx   = csum;
        cnt_nx    = cnt;
        txdata_nx = txdata;
        txclk_nx  = (state == STROBE);
        busy_nx   = (state == LOAD) || (state == STROBE) ||
                    (state == WAIT_BUSY) || (state == WAIT_READY);
        done_nx   = (state == DONE);
        unique case (state)
            IDLE: begin
                // done is still high in the first IDLE cycle; that start is dropped.
                if (start && !busy && !done) begin
                    snap_nx  = pattern;
                    idx_nx   = 4'd0;
                    csum_nx  = 8'h00;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (txready) begin
                    txdata_nx = cur_byte;
                    if (idx <= 4'd8)
                        csum_nx = csum + cur_byte;
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                cnt_nx   = 8'h00;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A UART that never drops ready is assumed to have taken the byte.
                if (!txready || cnt == TMO_LAST)
                    state_nx = WAIT_READY;
                else
                    cnt_nx = cnt + 8'd1;
            end
            WAIT_READY: begin
                if (txready) begin
                    if (idx == IDX_LAST) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 4'd1;
                        state_nx = LOAD;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            snap   <= 32'h0;
            csum   <= 8'h00;
            cnt    <= 8'h00;
            txdata <= 8'h00;
            txclk  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            snap   <= snap_nx;
            csum   <= csum_nx;
            cnt    <= cnt_nx;
            txdata <= txdata_nx;
            txclk  <= txclk_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_pattern_dump_tx.sv
// tb_pattern_dump_tx: directed bench for pattern_dump_tx with a byte scoreboard
// and a small UART model whose ready behaviour is selectable.
module tb_pattern_dump_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pattern;
    logic        txready;
    logic [7:0]  txdata;
    logic        txclk;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int txclk_cnt = 0;
    int done_cnt  = 0;
    int uart_mode = 0;   // 0 = ideal, 1 = ready stuck high, 2 = ready held low
    logic [7:0] exp_q[$];

    pattern_dump_tx #(
        .HEADER      (8'hA5),
        .TERM        (8'h0A),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .txready(txready),
        .txdata (txdata),
        .txclk  (txclk),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    task automatic push_frame(input logic [31:0] p);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            b = hex_ascii(p[4*i +: 4]);
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(sum);
        exp_q.push_back(8'h0A);
    endtask

    // UART model: in ideal mode ready drops for the cycle after each strobe.
    always @(negedge clk) begin
        case (uart_mode)
            0: txready = ~txclk;
            1: txready = 1'b1;
            default: txready = 1'b0;
        endcase
    end

    // Scoreboard monitor: every strobe must match the next expected byte.
    always @(posedge clk) begin
        #1;
        if (txclk) begin
            txclk_cnt++;
            if (exp_q.size() == 0) check("unexpected_txclk", {24'h0, txdata}, 32'hFFFF_FFFF);
            else check("byte", {24'h0, txdata}, {24'h0, exp_q.pop_front()});
        end
        if (done) done_cnt++;
    end

    task automatic post_frame(input int tx0, input int dn0);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_pulse", {31'h0, done}, 32'h0);
        check("busy_after_done", {31'h0, busy}, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        check("txclk_count", txclk_cnt - tx0, 11);
        check("done_count", done_cnt - dn0, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_frame(input logic [31:0] p, input bit disturb,
                             input int exp_done_cyc, input int exp_first_tx);
        int cyc;
        int first_tx;
        int tx0;
        int dn0;
        bit seen;
        tx0 = txclk_cnt;
        dn0 = done_cnt;
        pattern = p;
        push_frame(p);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        first_tx = -1;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (txclk && first_tx < 0) first_tx = cyc;
            if (done) seen = 1'b1;
            if (disturb && cyc == 10) begin
                pattern = ~p;
                start = 1'b1;
            end else if (disturb && cyc == 11) begin
                start = 1'b0;
            end
        end
        check("done_seen", {31'h0, seen}, 32'h1);
        check("done_latency", cyc, exp_done_cyc);
        check("first_txclk_latency", first_tx, exp_first_tx);
        if (disturb) start = 1'b1;   // start while done is high
        post_frame(tx0, dn0);
    endtask

    initial begin
        int tx0;
        int dn0;
        int cyc;
        int seen_tx;
        bit saw;
        rst = 1'b0;
        start = 1'b0;
        pattern = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txdata", {24'h0, txdata}, 32'h0);
        check("rst_txclk", {31'h0, txclk}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Ideal UART frames
        run_frame(32'h0000_0000, 1'b0, 45, 2);
        run_frame(32'h0000_0001, 1'b0, 45, 2);
        run_frame(32'hFEDC_BA98, 1'b1, 45, 2);

        // Ready never drops: every byte waits out the timeout
        uart_mode = 1;
        run_frame(32'hFEDC_BA98, 1'b0, 210, 2);

        // Ready held low at LOAD for 50 cycles
        uart_mode = 2;
        @(posedge clk); #1;
        tx0 = txclk_cnt;
        dn0 = done_cnt;
        pattern = 32'h3141_5926;
        push_frame(pattern);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (txclk) saw = 1'b1;
            if (i == 20) start = 1'b1;
            if (i == 21) start = 1'b0;
        end
        check("stall_no_txclk", {31'h0, saw}, 32'h0);
        check("stall_busy", {31'h0, busy}, 32'h1);
        uart_mode = 0;
        @(negedge clk);
        @(posedge clk); #1;
        check("stall_txclk_c1", {31'h0, txclk}, 32'h0);
        @(posedge clk); #1;
        check("stall_txclk_c2", {31'h0, txclk}, 32'h1);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stall_done_seen", {31'h0, done}, 32'h1);
        post_frame(tx0, dn0);

        // Reset after the strobe of byte 4 aborts the frame
        tx0 = txclk_cnt;
        pattern = 32'h7654_3210;
        push_frame(pattern);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen_tx = 0;
        cyc = 0;
        while (seen_tx < 5 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (txclk) seen_tx++;
        end
        check("abort_reached_byte4", seen_tx, 5);
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_txdata", {24'h0, txdata}, 32'h0);
        check("abort_txclk", {31'h0, txclk}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_more_txclk", txclk_cnt - tx0, 5);
        check("abort_idle_busy", {31'h0, busy}, 32'h0);
        run_frame(32'h89AB_CDEF, 1'b0, 45, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
